// File: rtl/aes_top_pack.sv
// Shared AES peripheral constants plus the stream word-stats register map.
package aes_top_pack;

   localparam int ADDRESS_SIZE = 32;
   localparam int REG_SIZE     = 32;

   localparam logic [ADDRESS_SIZE-1:0] PERIPHERAL_ADDR = 32'h0000_1000;

   localparam int STATS_MAX_CH    = 16;
   localparam int CTRL_SAT_BIT    = 0;
   localparam int CTRL_COR_BIT    = 1;
   localparam int CTRL_FREEZE_BIT = 2;

   // Byte offsets from the window base; CTRL and OVF follow the counters.
   function automatic logic [ADDRESS_SIZE-1:0] stats_cnt_off(
      input int unsigned i
   );
      return ADDRESS_SIZE'(4 * i);
   endfunction

   function automatic logic [ADDRESS_SIZE-1:0] stats_ctrl_off(
      input int unsigned n
   );
      return ADDRESS_SIZE'(4 * n);
   endfunction

   function automatic logic [ADDRESS_SIZE-1:0] stats_ovf_off(
      input int unsigned n
   );
      return ADDRESS_SIZE'(4 * n + 4);
   endfunction

endpackage

// File: rtl/aes_stat_counter.sv
// One beat counter: load/clear pick the base, then a beat adds one.
module aes_stat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         load_i,
   input  logic [W-1:0] loadval_i,
   input  logic         clear_i,
   input  logic         sat_i,
   output logic [W-1:0] cnt_o,
   output logic         ovf_o
);

   logic [W-1:0] cnt_q, cnt_d, base;

   // Beat is applied on top of a same-cycle load or clear so none is lost.
   always_comb begin
      base  = load_i ? loadval_i : (clear_i ? '0 : cnt_q);
      cnt_d = base;
      ovf_o = 1'b0;
      if (inc_i) begin
         if (&base) begin
            ovf_o = 1'b1;
            cnt_d = sat_i ? base : '0;
         end else begin
            cnt_d = base + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_stream_word_stats.sv
// Per-channel stream beat counters with an Avalon-MM register slave.
module aes_stream_word_stats
   import aes_top_pack::*;
#(
   parameter int                      N_CH      = 3,
   parameter int                      CNT_WIDTH = 8,
   parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR = PERIPHERAL_ADDR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         beat_i,
   input  logic [ADDRESS_SIZE-1:0] avs_address,
   input  logic                    avs_read,
   input  logic                    avs_write,
   input  logic [REG_SIZE-1:0]     avs_writedata,
   output logic [REG_SIZE-1:0]     avs_readdata,
   output logic                    avs_readdatavalid,
   output logic                    avs_waitrequest,
   output logic                    ovf_irq_o
);

   logic [ADDRESS_SIZE-1:0] off;
   logic                    in_win;
   logic                    ctrl_hit, ovf_hit;
   logic [N_CH-1:0]         cnt_hit;
   logic [N_CH-1:0]         ovf_pulse;
   logic [CNT_WIDTH-1:0]    cnt [N_CH];

   logic [2:0]          ctrl_q, ctrl_d;
   logic [N_CH-1:0]     ovf_q, ovf_d;
   logic [REG_SIZE-1:0] rdata_q, rdata_d;
   logic                rvalid_q, irq_q;
   logic                unused_wd;

   assign off      = avs_address - BASE_ADDR;
   assign in_win   = (avs_address >= BASE_ADDR) && (off[1:0] == 2'b00);
   assign ctrl_hit = in_win && (off == stats_ctrl_off(N_CH));
   assign ovf_hit  = in_win && (off == stats_ovf_off(N_CH));

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign cnt_hit[i] = in_win && (off == stats_cnt_off(i));

      aes_stat_counter #(.W(CNT_WIDTH)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc_i     (beat_i[i] & ~ctrl_q[CTRL_FREEZE_BIT]),
         .load_i    (avs_write & cnt_hit[i]),
         .loadval_i (avs_writedata[CNT_WIDTH-1:0]),
         .clear_i   (avs_read & ctrl_q[CTRL_COR_BIT] & cnt_hit[i]),
         .sat_i     (ctrl_q[CTRL_SAT_BIT]),
         .cnt_o     (cnt[i]),
         .ovf_o     (ovf_pulse[i])
      );
   end

   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cnt_hit[i]) rdata_d = REG_SIZE'(cnt[i]);
      end
      if (ctrl_hit) rdata_d = REG_SIZE'(ctrl_q);
      if (ovf_hit)  rdata_d = REG_SIZE'(ovf_q);
   end

   // A fresh overflow wins over a same-cycle write-1-to-clear.
   always_comb begin
      ctrl_d = ctrl_q;
      ovf_d  = ovf_q;
      if (avs_write && ctrl_hit) ctrl_d = avs_writedata[2:0];
      if (avs_write && ovf_hit)  ovf_d  = ovf_q & ~avs_writedata[N_CH-1:0];
      ovf_d = ovf_d | ovf_pulse;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q   <= '0;
         ovf_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         ovf_q    <= ovf_d;
         rvalid_q <= avs_read;
         irq_q    <= |ovf_q;
         if (avs_read) rdata_q <= rdata_d;
      end
   end

   assign unused_wd         = ^avs_writedata;
   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;
   assign avs_waitrequest   = 1'b0;
   assign ovf_irq_o         = irq_q;

endmodule

// File: doc/aes_stream_word_stats.md
# aes_stream_word_stats

Parametrised per-channel stream-beat counter bank with an Avalon-MM register slave, the successor to the fixed three-counter (message/adder/remover) word counting in the AES datapath. It counts accepted beats on N_CH stream taps (e.g. MAC RX, IP-header adder, header remover), supports wrap or saturate modes, clear-on-read, freeze, and sticky overflow flags. It sits beside the AES stream pipeline and is read by the host over the peripheral Avalon-MM bus.

## Interface
- N_CH, 3: number of counted channels, 1..16
- CNT_WIDTH, 8: counter width, 1..REG_SIZE
- BASE_ADDR, PERIPHERAL_ADDR: byte base address of the register window
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- beat_i  in  N_CH  per-channel accepted beat (valid&ready already qualified), 1 = count one
- avs_address  in  ADDRESS_SIZE  byte address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  REG_SIZE  write data
- avs_readdata  out  REG_SIZE  read data
- avs_readdatavalid  out  1  read data valid
- avs_waitrequest  out  1  constant 0
- ovf_irq_o  out  1  registered OR of sticky overflow flags

## Operation
- Register map (offset from BASE_ADDR, byte-addressed, 4-byte stride):
  - 0x00 + 4*i, i < N_CH: CNT[i], R/W; read returns counter zero-extended; write loads avs_writedata[CNT_WIDTH-1:0]
  - 0x00 + 4*N_CH: CTRL, R/W; bit0 SAT (1 = saturate at all-ones, 0 = wrap), bit1 COR (clear-on-read), bit2 FREEZE (ignore beats); other bits read 0
  - 0x04 + 4*N_CH: OVF, bits[N_CH-1:0] sticky overflow, write-1-to-clear
- Any other address, or address[1:0] != 0: read returns 0, write ignored; no error response.
- Increment: on beat_i[i] && !FREEZE, CNT[i] += 1.
  - Wrap mode: all-ones + 1 -> 0, set OVF[i].
  - Saturate mode: all-ones stays all-ones, set OVF[i] on the attempted increment.
- Same-cycle events on one channel, no beat ever lost:
  - COR read + beat: read returns pre-increment value; counter becomes 1.
  - Write + beat: counter = writedata + 1 (wrap/saturate rules apply; overflow from this sum sets OVF).
  - Read and write strobes together: write executes, read returns pre-write value.
- OVF write-1-to-clear and a new overflow on the same bit in the same cycle: bit stays set.
- Writing CTRL never modifies counters; clearing FREEZE resumes counting on the next cycle.

## Timing
- Read latency fixed 1: avs_readdatavalid pulses 1 cycle after avs_read, with avs_readdata valid in that cycle; avs_readdata holds its value otherwise. Back-to-back reads every cycle are supported.
- Writes take effect at the clock edge that samples avs_write; read-after-write on the next cycle returns the new value.
- A beat sampled at edge k is visible to a read issued at edge k+1.
- ovf_irq_o asserts 1 cycle after the OVF bit sets, and deasserts 1 cycle after the last bit clears.
- Reset (any cycle, including mid-read): all CNT, CTRL, and OVF = 0; avs_readdata = 0; avs_readdatavalid = 0; ovf_irq_o = 0. A read in flight at reset is dropped, and no readdatavalid follows.

## Structure
- Extend aes_top_pack with: STATS_MAX_CH = 16; CTRL bit indices (CTRL_SAT_BIT = 0, CTRL_COR_BIT = 1, CTRL_FREEZE_BIT = 2); offset functions for the CNT/CTRL/OVF addresses in terms of N_CH. Reuse ADDRESS_SIZE, REG_SIZE, and PERIPHERAL_ADDR.
- One sub-module, aes_stat_counter: a single CNT_WIDTH counter with inc, load/loadval, clear, sat, and an ovf pulse. It is instantiated N_CH times in a generate loop. Address decode and the readback mux live in the top.

## Test plan
- Reset, then 5 beats on ch1 and read CNT[1] (offset 0x04) -> readdatavalid one cycle after read, data 5; CNT[0] and CNT[2] read 0.
- Wrap mode, CNT_WIDTH = 8: write CNT[0] = 0xFE, then 3 beats -> CNT[0] = 0x01, OVF = 0x1, ovf_irq_o = 1; write 0x1 to OVF -> OVF = 0, irq drops 1 cycle later.
- Saturate mode (CTRL = 0x1): write 0xFE, then 3 beats -> CNT = 0xFF, OVF[0] set.
- COR (CTRL = 0x2): counter = 7, read coincident with a beat -> readdata 7, then the next read returns 1.
- FREEZE (CTRL = 0x4): 10 beats -> counters unchanged; write to CNT[2] with a coincident beat (freeze off), writedata 0x10 -> 0x11.
- Reads of unmapped offsets 0x40 and 0x02 -> data 0 with readdatavalid; assert rst during a pending read -> no readdatavalid, and all registers read 0 afterwards.
